// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed-length level pulses separated by a minimum gap,
// queueing up to 15 further events and flagging any that had to be dropped.
module pulse_stretcher #(
  parameter int unsigned PULSE_TIME_MS = 100,
  parameter int unsigned GAP_TIME_MS   = 50,
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_a_p,
  input  logic       pulse_in,
  output logic       level_out,
  output logic       busy,
  output logic [3:0] pending,
  output logic       overflow
);

  localparam int unsigned CYC_PER_MS  = CLK_FREQ_HZ / 1000;
  localparam int unsigned HIGH_CYCLES = PULSE_TIME_MS * CYC_PER_MS;
  localparam int unsigned GAP_CYCLES  = GAP_TIME_MS * CYC_PER_MS;
  localparam int unsigned MAX_CYCLES  = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W       = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       pending_nxt;
  logic             overflow_nxt;
  logic             inc, dec;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + CNT_W'(1);
    dec          = 1'b0;
    pending_nxt  = pending;
    overflow_nxt = overflow;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pending != 4'd0 || pulse_in) begin
          state_nxt = HIGH;
          dec       = (pending != 4'd0);
        end
      end
      HIGH: begin
        if (cnt == HIGH_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (pending != 4'd0) begin
            state_nxt = HIGH;
            dec       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // An event arriving in IDLE with nothing queued starts directly and is never queued.
    inc = pulse_in && !(state == IDLE && pending == 4'd0);

    if (inc && !dec) begin
      if (pending == 4'hF) overflow_nxt = 1'b1;
      else                 pending_nxt  = pending + 4'd1;
    end else if (dec && !inc) begin
      pending_nxt = pending - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= 4'd0;
      overflow  <= 1'b0;
      level_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pending   <= pending_nxt;
      overflow  <= overflow_nxt;
      level_out <= (state_nxt == HIGH);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule
